replay_fifo: RTL and testbench
==============================

# replay_fifo

Parametrised successor to the sample FIFO: a single-clock, synchronous FIFO of WIDTH×DEPTH words with a mark/rewind replay window, flush, threshold flags, occupancy outputs and sticky error flags. While a mark is active, words behind the mark stay protected from overwrite, so a consumer can rewind and re-read them safely. The block sits between a sample producer and a consumer that may need to replay a burst, for example on a downstream retry.

## Interface
- WIDTH, 16, data word width (≥1)
- DEPTH, 64, number of entries; power of two, ≥4; AW = log2(DEPTH)
- AFULL_TH, DEPTH-4, o_afull asserts when retained ≥ AFULL_TH
- AEMPTY_TH, 4, o_aempty asserts when count ≤ AEMPTY_TH

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_flush  in  1  empty FIFO, drop mark, clear sticky flags
- i_mark  in  1  set mark at current read pointer
- i_rewind  in  1  reload read pointer from mark
- i_release  in  1  drop mark, free the protected region
- i_push  in  1  write request
- i_rear  in  WIDTH  write data
- o_full  out  1  no free entry (retained == DEPTH)
- o_afull  out  1  almost full
- i_pop  in  1  read request
- o_front  out  WIDTH  read data, registered
- o_vld  out  1  o_front is valid this cycle
- o_empty  out  1  count == 0
- o_aempty  out  1  almost empty
- o_count  out  AW+1  unread words (wptr − rptr)
- o_free  out  AW+1  writable entries (DEPTH − retained)
- o_mark_active  out  1  mark is held
- o_overflow  out  1  sticky: push attempted while full
- o_underflow  out  1  sticky: pop attempted while empty
- o_rptr, o_wptr  out  AW+1  raw pointers, including the wrap bit

## Operation
- Pointers wptr, rptr and mptr are AW+1 bits. The MSB is the wrap bit; RAM is addressed by the low AW bits. All arithmetic is modulo 2^(AW+1).
- base = o_mark_active ? mptr : rptr. retained = wptr − base. count = wptr − rptr.
- Push is accepted when i_push && !o_full: write RAM[wptr], then wptr+1. When full, the word is dropped and o_overflow is set. There is no same-cycle pop bypass: a push while full is rejected even if a pop occurs in the same cycle.
- Pop is accepted when i_pop && !o_empty && !i_rewind: read RAM[rptr], then rptr+1. Pop when empty sets o_underflow and does nothing else.
- Push while empty, together with a pop in the same cycle: the pop is rejected (underflow set) and the push is accepted.
- i_mark: mptr ← rptr value at the start of the cycle, and o_mark_active ← 1. If a pop is accepted in the same cycle, the popped word is the first word of the marked region. A new mark replaces the old one.
- i_rewind: if o_mark_active, rptr ← mptr and the mark stays active; otherwise the request is ignored. A pop in the same cycle is ignored, with no underflow and no o_vld.
- i_release: o_mark_active ← 0, and the protected words become free the next cycle.
- Command priority per cycle: rst > i_flush > i_rewind > i_mark > i_release. Lower-priority commands in the same cycle are ignored. Push is processed alongside every command except flush.
- i_flush: wptr = rptr = mptr = 0, mark cleared, o_overflow/o_underflow cleared, o_vld ← 0. Push and pop in that cycle are ignored. RAM contents are don't-care.
- o_front holds its last value when no pop is accepted.

## Timing
- Reset values: o_front = 0, o_vld = 0, all pointers = 0, o_mark_active = 0, o_overflow = o_underflow = 0, o_empty = 1, o_aempty = 1, o_full = 0, o_afull = 0, o_count = 0, o_free = DEPTH.
- Read latency is 1: a pop accepted at edge N gives o_front/o_vld valid after edge N; o_vld is high for exactly one cycle per accepted pop.
- Status outputs are combinational from registered pointers, so they reflect an event in the cycle after its edge.
- Write-to-read: a word pushed at edge N is poppable at edge N+1.
- Rewind at edge N: the next accepted pop, at edge ≥ N+1, returns RAM[mptr].
- Full/empty are unambiguous via the wrap bit: equal low bits with equal MSB means empty (count = 0); equal low bits with differing MSB means count = DEPTH.
- rst asserted mid-operation overrides every input in that cycle.

## Test plan
- DEPTH=8: push 0..9 continuously → words 0..7 accepted, o_full after the 8th push, o_overflow = 1, o_count = 8, o_free = 0; then pop 8 → o_front = 0..7, each one cycle after its pop, then o_empty = 1.
- Push 0..5, pop 2, i_mark, pop 3 (o_front 2,3,4), i_rewind, pop 3 → o_front 2,3,4 again; o_mark_active stays 1.
- DEPTH=8 with mark held at rptr=0: pop 8 of 8, then push → rejected, o_full = 1, o_count = 0; assert i_release → o_free = 8 next cycle and a push succeeds.
- Mid-stream i_flush with mark set and o_overflow = 1 → next cycle o_count = 0, o_empty = 1, o_mark_active = 0, o_overflow = 0, o_vld = 0; then push 0..19 / pop 0..19 across two wraps → data intact.
- Pop on an empty FIFO → o_underflow = 1, no o_vld. i_rewind with no mark → rptr unchanged. i_rewind together with i_pop → no o_vld that cycle.
- AFULL_TH = 6, AEMPTY_TH = 2, DEPTH = 8: fill one word per cycle → o_aempty deasserts at count = 3 and o_afull asserts at count = 6. Assert rst mid-fill → all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/replay_fifo.sv
// Single-clock FIFO with a mark/rewind replay window: words behind an active
// mark are retained (not overwritable) so the consumer can rewind and re-read.
module replay_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_mark,
  input  logic                      i_rewind,
  input  logic                      i_release,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_rear,
  output logic                      o_full,
  output logic                      o_afull,
  input  logic                      i_pop,
  output logic [WIDTH-1:0]          o_front,
  output logic                      o_vld,
  output logic                      o_empty,
  output logic                      o_aempty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [$clog2(DEPTH):0]    o_free,
  output logic                      o_mark_active,
  output logic                      o_overflow,
  output logic                      o_underflow,
  output logic [$clog2(DEPTH):0]    o_rptr,
  output logic [$clog2(DEPTH):0]    o_wptr
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] LP_AEMPTY = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] LP_ONE    = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      r_mptr;
  logic             r_mark;
  logic             r_ovf;
  logic             r_udf;
  logic             r_vld;
  logic [WIDTH-1:0] r_front;

  logic [AW:0]      w_base;
  logic [AW:0]      w_retained;
  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // While a mark is held, the oldest retained word is at the mark, not at rptr.
  assign w_base     = r_mark ? r_mptr : r_rptr;
  assign w_retained = r_wptr - w_base;
  assign w_count    = r_wptr - r_rptr;
  assign w_full     = (w_retained == LP_DEPTH);
  assign w_empty    = (w_count == '0);

  assign w_push_ok  = i_push && !w_full && !i_flush;
  assign w_pop_ok   = i_pop && !w_empty && !i_rewind && !i_flush;

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_rear;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mptr  <= '0;
      r_mark  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_vld   <= 1'b0;
      r_front <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_mptr  <= '0;
      r_mark  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      if (w_push_ok) begin
        r_wptr <= r_wptr + LP_ONE;
      end else if (i_push) begin
        r_ovf <= 1'b1;
      end
      // Rewind outranks mark/release and swallows any same-cycle pop silently.
      if (i_rewind) begin
        if (r_mark) begin
          r_rptr <= r_mptr;
        end
      end else begin
        if (w_pop_ok) begin
          r_front <= r_mem[r_rptr[AW-1:0]];
          r_rptr  <= r_rptr + LP_ONE;
          r_vld   <= 1'b1;
        end else if (i_pop) begin
          r_udf <= 1'b1;
        end
        if (i_mark) begin
          r_mptr <= r_rptr;
          r_mark <= 1'b1;
        end else if (i_release) begin
          r_mark <= 1'b0;
        end
      end
    end
  end

  assign o_front       = r_front;
  assign o_vld         = r_vld;
  assign o_full        = w_full;
  assign o_afull       = (w_retained >= LP_AFULL);
  assign o_empty       = w_empty;
  assign o_aempty      = (w_count <= LP_AEMPTY);
  assign o_count       = w_count;
  assign o_free        = LP_DEPTH - w_retained;
  assign o_mark_active = r_mark;
  assign o_overflow    = r_ovf;
  assign o_underflow   = r_udf;
  assign o_rptr        = r_rptr;
  assign o_wptr        = r_wptr;

endmodule

// File: tb/tb_replay_fifo.sv
// Bench for replay_fifo: directed scenarios plus random traffic, all checked
// every cycle against a sequence-number reference model.
module tb_replay_fifo;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, i_flush, i_mark, i_rewind, i_release, i_push, i_pop;
  logic [WIDTH-1:0] i_rear, o_front;
  logic             o_full, o_afull, o_vld, o_empty, o_aempty;
  logic             o_mark_active, o_overflow, o_underflow;
  logic [AW:0]      o_count, o_free, o_rptr, o_wptr;

  replay_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_mark(i_mark),
    .i_rewind(i_rewind), .i_release(i_release), .i_push(i_push),
    .i_rear(i_rear), .o_full(o_full), .o_afull(o_afull), .i_pop(i_pop),
    .o_front(o_front), .o_vld(o_vld), .o_empty(o_empty), .o_aempty(o_aempty),
    .o_count(o_count), .o_free(o_free), .o_mark_active(o_mark_active),
    .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_rptr(o_rptr), .o_wptr(o_wptr)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: unbounded write/read/mark sequence numbers, data keyed by sequence.
  int               m_wr = 0, m_rd = 0, m_mk = 0;
  bit               m_mact = 0, m_ovf = 0, m_udf = 0, m_vld = 0;
  logic [WIDTH-1:0] m_front = '0;
  logic [WIDTH-1:0] m_data [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int cnt, ret;
    cnt = m_wr - m_rd;
    ret = m_wr - (m_mact ? m_mk : m_rd);
    chk("front",     32'(o_front),       32'(m_front));
    chk("vld",       32'(o_vld),         32'(m_vld));
    chk("count",     32'(o_count),       32'(cnt));
    chk("free",      32'(o_free),        32'(DEPTH - ret));
    chk("empty",     32'(o_empty),       32'(cnt == 0));
    chk("aempty",    32'(o_aempty),      32'(cnt <= AEMPTY_TH));
    chk("full",      32'(o_full),        32'(ret == DEPTH));
    chk("afull",     32'(o_afull),       32'(ret >= AFULL_TH));
    chk("mark",      32'(o_mark_active), 32'(m_mact));
    chk("overflow",  32'(o_overflow),    32'(m_ovf));
    chk("underflow", 32'(o_underflow),   32'(m_udf));
    chk("rptr",      32'(o_rptr),        32'(m_rd % (2 * DEPTH)));
    chk("wptr",      32'(o_wptr),        32'(m_wr % (2 * DEPTH)));
  endtask

  task automatic step(input bit push, input logic [WIDTH-1:0] d, input bit pop,
                      input bit mk = 0, input bit rw = 0, input bit rl = 0,
                      input bit fl = 0, input bit r = 0);
    int cnt, ret, old_rd;
    i_push = push; i_rear = d; i_pop = pop; i_mark = mk;
    i_rewind = rw; i_release = rl; i_flush = fl; rst = r;
    @(posedge clk);
    cnt    = m_wr - m_rd;
    ret    = m_wr - (m_mact ? m_mk : m_rd);
    old_rd = m_rd;
    if (r) begin
      m_wr = 0; m_rd = 0; m_mk = 0; m_mact = 0; m_ovf = 0; m_udf = 0;
      m_vld = 0; m_front = '0;
    end else if (fl) begin
      m_wr = 0; m_rd = 0; m_mk = 0; m_mact = 0; m_ovf = 0; m_udf = 0; m_vld = 0;
    end else begin
      m_vld = 0;
      if (push) begin
        if (ret == DEPTH) m_ovf = 1;
        else begin m_data[m_wr] = d; m_wr++; end
      end
      if (rw) begin
        if (m_mact) m_rd = m_mk;
      end else begin
        if (pop) begin
          if (cnt == 0) m_udf = 1;
          else begin m_front = m_data[old_rd]; m_rd = old_rd + 1; m_vld = 1; end
        end
        if (mk) begin m_mk = old_rd; m_mact = 1; end
        else if (rl) m_mact = 0;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    int bias;
    // reset
    step(0, '0, 0, 0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0, 0, 1);
    chk("rst_free", 32'(o_free), 32'd8);
    chk("rst_empty", 32'(o_empty), 32'd1);

    // fill past full, then drain
    for (int i = 0; i < 10; i++) step(1, 16'(i), 0);
    chk("fill_count", 32'(o_count), 32'd8);
    chk("fill_free", 32'(o_free), 32'd0);
    chk("fill_ovf", 32'(o_overflow), 32'd1);
    chk("fill_full", 32'(o_full), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1);
      chk("drain_front", 32'(o_front), 32'(i));
    end
    chk("drain_empty", 32'(o_empty), 32'd1);

    // mark / rewind replay
    step(0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 16'(i), 0);
    step(0, '0, 1); step(0, '0, 1);
    step(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      chk("replay1", 32'(o_front), 32'(i + 2));
    end
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1);
      chk("replay2", 32'(o_front), 32'(i + 2));
    end
    chk("replay_mark", 32'(o_mark_active), 32'd1);

    // mark protects a full window; release frees it
    step(0, '0, 0, 0, 0, 0, 1);
    step(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 16'(100 + i), 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    step(1, 16'hBEEF, 0);
    chk("prot_full", 32'(o_full), 32'd1);
    chk("prot_count", 32'(o_count), 32'd0);
    step(0, '0, 0, 0, 0, 1);
    chk("rel_free", 32'(o_free), 32'd8);
    step(1, 16'h1234, 0);
    chk("rel_push", 32'(o_count), 32'd1);

    // flush with mark and overflow set, then stream through two wraps
    step(0, '0, 0, 1);
    step(0, '0, 0, 0, 0, 0, 1);
    chk("flush_mark", 32'(o_mark_active), 32'd0);
    chk("flush_ovf", 32'(o_overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1, 16'(i), i > 0);
      if (i > 0) chk("stream", 32'(o_front), 32'(i - 1));
    end
    step(0, '0, 1);
    chk("stream_last", 32'(o_front), 32'd19);

    // underflow, rewind without mark, rewind with pop
    step(0, '0, 1);
    chk("udf", 32'(o_underflow), 32'd1);
    chk("udf_vld", 32'(o_vld), 32'd0);
    step(1, 16'd7, 0); step(1, 16'd8, 0); step(0, '0, 1);
    step(0, '0, 0, 0, 1);
    chk("rew_nomark", 32'(o_count), 32'd1);
    step(0, '0, 1, 0, 1);
    chk("rew_pop_vld", 32'(o_vld), 32'd0);

    // thresholds while filling, then reset mid-fill
    step(0, '0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(1, 16'(i), 0);
      chk("th_aempty", 32'(o_aempty), 32'(i <= 2));
      chk("th_afull", 32'(o_afull), 32'(i >= 6));
    end
    step(0, '0, 1, 1);
    step(1, 16'd1, 0); step(1, 16'd2, 0);
    step(1, 16'd3, 1, 0, 0, 0, 0, 1);
    chk("midrst_count", 32'(o_count), 32'd0);
    chk("midrst_mark", 32'(o_mark_active), 32'd0);
    chk("midrst_front", 32'(o_front), 32'd0);

    // random traffic
    bias = 50;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) bias = $urandom_range(15, 85);
      step($urandom_range(99) < bias, 16'($urandom), $urandom_range(99) >= bias,
           $urandom_range(99) < 4, $urandom_range(99) < 3, $urandom_range(99) < 4,
           $urandom_range(999) < 5, $urandom_range(999) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
